// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one-cycle-latency imem reads and buffers returns in a 2-entry FIFO.
// Redirect flushes buffered and in-flight words and issues the target read in the same cycle.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr
);

  logic [31:0] pc_q;
  logic [31:0] infl_pc;
  logic        infl_v;
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;
  logic [2:0] limit;

  assign fetch_valid = (count != 2'd0);
  assign fetch_pc    = fetch_valid ? buf_pc[rd_ptr]    : 32'h0;
  assign fetch_instr = fetch_valid ? buf_instr[rd_ptr] : NOP_INSTR;

  assign pop  = fetch_valid & ~stall & ~redirect;
  assign push = infl_v & ~redirect;

  // A free credit exists when buffered + in-flight words leave room after this cycle's pop.
  assign occ   = {1'b0, count} + {2'b00, infl_v};
  assign limit = 3'd2 + {2'b00, pop};
  assign issue = redirect | (occ < limit);

  assign imem_rd_en = reset & issue;
  assign imem_addr  = redirect ? {redirect_pc[31:2], 2'b00} : pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      infl_v  <= 1'b0;
      infl_pc <= 32'h0;
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
    end else begin
      infl_v <= issue;
      if (issue) begin
        pc_q    <= imem_addr + 32'd4;
        infl_pc <= imem_addr;
      end
      if (redirect) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        if (push && !pop)      count <= count + 2'd1;
        else if (pop && !push) count <= count - 2'd1;
      end
    end
  end

  // Payload storage needs no reset: fetch_valid masks it while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= infl_pc;
      buf_instr[wr_ptr] <= imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && count == 2'd2));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: program-order reference stream per fetch epoch plus
// timing rules (two-cycle bubble after reset/redirect, never a bubble afterwards).
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int since = -1;
  int run;
  logic [31:0] tgt;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr)
  );

  // Synchronous memory: word index as data; garbage when not read so stale captures show up.
  always @(posedge clk) imem_rdata <= imem_rd_en ? (imem_addr >> 2) : $urandom;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A new fetch epoch: program order is sequential words from the base, wrapping at 2^32.
  task automatic start_stream(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 400; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    start_stream({pc[31:2], 2'b00});
  endtask

  // Monitor: samples mid-cycle, compares the head against program order, consumes on pop.
  always @(negedge clk) begin
    if (!reset) begin
      since = -1;
    end else if (redirect) begin
      since = 0;
      check("redir_rd_en", {31'b0, imem_rd_en}, 32'd1);
      check("redir_addr", imem_addr, {redirect_pc[31:2], 2'b00});
    end else begin
      since = since + 1;
      if (since <= 1) check("bubble_valid", {31'b0, fetch_valid}, 32'd0);
      else            check("stream_valid", {31'b0, fetch_valid}, 32'd1);
      if (!fetch_valid) begin
        check("bubble_instr", fetch_instr, NOP_INSTR);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got pc %h expected no instruction", fetch_pc);
      end else begin
        check("sb_pc", fetch_pc, exp_q[0]);
        check("sb_instr", fetch_instr, exp_q[0] >> 2);
        if (!stall) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_pc", fetch_pc, 32'h0);
    check("rst_instr", fetch_instr, NOP_INSTR);
    check("rst_rd_en", {31'b0, imem_rd_en}, 32'd0);

    // Sequential fetch from reset
    reset = 1'b1;
    start_stream(RESET_PC);
    #1;
    check("c0_rd_en", {31'b0, imem_rd_en}, 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    step(); check("c1_addr", imem_addr, 32'h4);
    step(); check("c2_addr", imem_addr, 32'h8);
    check("c2_pc", fetch_pc, 32'h0);
    check("c2_instr", fetch_instr, 32'h0);
    step(); step();
    check("c4_pc", fetch_pc, 32'h8);

    // Stall with head at 0x8
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_head", fetch_pc, 32'h8);
      if (i > 0) check("stall_no_issue", {31'b0, imem_rd_en}, 32'd0);
      step();
    end
    stall = 1'b0;
    repeat (6) step();

    // Redirect with a full buffer
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    do_redirect(32'h100);
    #1;
    check("redir_full_addr", imem_addr, 32'h100);
    step(); redirect = 1'b0; #1;
    check("redir_bubble", {31'b0, fetch_valid}, 32'd0);
    step();
    check("redir_target", fetch_pc, 32'h100);
    repeat (5) step();

    // Redirect during stall, unaligned target
    stall = 1'b1;
    do_redirect(32'h203);
    #1;
    check("rs_addr", imem_addr, 32'h200);
    step(); redirect = 1'b0; #1;
    check("rs_bubble", {31'b0, fetch_valid}, 32'd0);
    step();
    check("rs_valid", {31'b0, fetch_valid}, 32'd1);
    check("rs_pc", fetch_pc, 32'h200);
    check("rs_instr", fetch_instr, 32'h80);
    repeat (2) step();
    stall = 1'b0;
    repeat (4) step();

    // Address wrap
    do_redirect(32'hFFFF_FFFC);
    #1;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(); redirect = 1'b0; #1;
    check("wrap_rd_en", {31'b0, imem_rd_en}, 32'd1);
    check("wrap_addr1", imem_addr, 32'h0);
    repeat (6) step();

    // Asynchronous reset mid-stream
    @(posedge clk);
    #4;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("arst_valid", {31'b0, fetch_valid}, 32'd0);
    check("arst_instr", fetch_instr, NOP_INSTR);
    check("arst_pc", fetch_pc, 32'h0);
    check("arst_rd_en", {31'b0, imem_rd_en}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    start_stream(RESET_PC);
    #1;
    check("restart_addr", imem_addr, RESET_PC);
    check("restart_rd_en", {31'b0, imem_rd_en}, 32'd1);
    repeat (6) step();

    // Random stall/redirect traffic
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      redirect = 1'b0;
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0 || run > 300) begin
        tgt = $urandom;
        case ($urandom_range(0, 2))
          0: tgt = tgt & 32'h0000_0FFF;
          1: tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
          default: ;
        endcase
        do_redirect(tgt);
        run = 0;
      end else begin
        run++;
      end
    end
    step();
    stall = 1'b0;
    redirect = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
